// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the Gray-code conversion scheduler.
// The state encoding is fixed so that debug probes and waveforms read
// the same across builds.
package gray_conv_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    // Job mode encoding carried on i_reqX_mode
    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary to reflected-Gray converter.
// Each Gray bit is the XOR of the binary bit and its upper neighbour.
module bin_to_gray #(
    parameter int N = 8
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_sched_rr_arb2.sv
// Two-input round-robin arbiter with its own priority pointer.
// A lone requester always wins; on contention the pointer side wins,
// and every grant hands priority to the other side.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic ptr;

    // Pick the winner; grant stays all-zero when nobody is asking
    always_comb begin
        grant_id = 1'b0;
        grant    = 2'b00;
        if (valid0 && valid1) begin
            grant_id = ptr;
        end else if (valid1) begin
            grant_id = 1'b1;
        end
        if (valid0 || valid1) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    // Move priority to the loser whenever a grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~grant_id;
        end
    end

endmodule

// File: rtl/gray_to_bin.sv
// Combinational reflected-Gray to binary converter.
// Binary bit i is the running XOR of all Gray bits from the MSB down to i.
module gray_to_bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    // Prefix XOR from the MSB; a local accumulator avoids reading the output back
    always_comb begin
        logic acc;
        acc = 1'b0;
        bin = '0;
        for (int i = N - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_conv_sched.sv
// Scheduler sharing one bin_to_gray and one gray_to_bin between two
// requesters. Jobs are granted round-robin, converted in CONV and held
// in RESP until the consumer takes them.
// Optional build macro: GRAY_CONV_CHECK_EN adds a round-trip self-check
// that drives a sticky o_chk_err; without it o_chk_err is tied low.
module gray_conv_sched
    import gray_conv_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic         i_req0_mode,
    input  logic [N-1:0] i_req0_data,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic         i_req1_mode,
    input  logic [N-1:0] i_req1_data,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [N-1:0] o_rsp_data,
    output logic         o_rsp_id,
    output logic         o_chk_err
);

    state_t       state;
    state_t       next_state;
    logic [1:0]   grant;
    logic         grant_id;
    logic         accept;
    logic         cap_mode;
    logic         cap_id;
    logic [N-1:0] cap_data;
    logic [N-1:0] b2g_out;
    logic [N-1:0] g2b_out;
    logic [N-1:0] conv_result;

    // A job is taken only from IDLE, and only when someone is asking
    assign accept = (state == IDLE) && (i_req0_valid || i_req1_valid);

    rr_arb2 u_arb (
        .clk      (i_clk),
        .rst_n    (i_rstn),
        .valid0   (i_req0_valid),
        .valid1   (i_req1_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Ready is masked by reset so both readies read 0 while reset is held
    assign o_req0_ready = i_rstn && (state == IDLE) && grant[0];
    assign o_req1_ready = i_rstn && (state == IDLE) && grant[1];
    assign o_rsp_valid  = (state == RESP);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic: one cycle of conversion, then hold until consumed
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = CONV;
            CONV: next_state = RESP;
            RESP: if (i_rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the granted requester's job at the accept edge
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cap_mode <= MODE_B2G;
            cap_id   <= 1'b0;
            cap_data <= '0;
        end else if (accept) begin
            cap_mode <= grant_id ? i_req1_mode : i_req0_mode;
            cap_id   <= grant_id;
            cap_data <= grant_id ? i_req1_data : i_req0_data;
        end
    end

    bin_to_gray #(.N(N)) u_b2g (
        .bin  (cap_data),
        .gray (b2g_out)
    );

    gray_to_bin #(.N(N)) u_g2b (
        .gray (cap_data),
        .bin  (g2b_out)
    );

    assign conv_result = (cap_mode == MODE_G2B) ? g2b_out : b2g_out;

    // Result and owner only change on the CONV to RESP edge
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rsp_data <= '0;
            o_rsp_id   <= 1'b0;
        end else if (state == CONV) begin
            o_rsp_data <= conv_result;
            o_rsp_id   <= cap_id;
        end
    end

`ifdef GRAY_CONV_CHECK_EN
    logic [N-1:0] chk_b2g;
    logic [N-1:0] chk_g2b;
    logic [N-1:0] round_trip;
    logic         chk_mismatch;
    logic         chk_err_q;

    bin_to_gray #(.N(N)) u_chk_b2g (
        .bin  (conv_result),
        .gray (chk_b2g)
    );

    gray_to_bin #(.N(N)) u_chk_g2b (
        .gray (conv_result),
        .bin  (chk_g2b)
    );

    // Undo the conversion with the opposite converter; it must give the operand back
    assign round_trip   = (cap_mode == MODE_G2B) ? chk_b2g : chk_g2b;
    assign chk_mismatch = (round_trip != cap_data);

    // Sticky error flag, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            chk_err_q <= 1'b0;
        end else if ((state == CONV) && chk_mismatch) begin
            chk_err_q <= 1'b1;
        end
    end

    assign o_chk_err = chk_err_q;
`else
    assign o_chk_err = 1'b0;
`endif

endmodule
